// File: rtl/m68k_bridge_pkg.sv
// Shared types, constants and packet helpers for the 68000-to-UART bus bridge.
package m68k_bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_A2,
        ST_SEND_A1,
        ST_SEND_A0,
        ST_SEND_DH,
        ST_SEND_DL,
        ST_WAIT_STATUS,
        ST_RECV_DH,
        ST_RECV_DL,
        ST_DONE_ACK,
        ST_DONE_ERR
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h15;

    // Header byte layout: {start, rw, uds, lds, reserved, fc[2:0]}
    localparam int unsigned HDR_START_BIT = 7;
    localparam int unsigned HDR_RW_BIT    = 6;
    localparam int unsigned HDR_UDS_BIT   = 5;
    localparam int unsigned HDR_LDS_BIT   = 4;
    localparam int unsigned HDR_RSVD_BIT  = 3;
    localparam int unsigned HDR_FC_LSB    = 0;

    localparam int unsigned READ_TX_LEN  = 4;
    localparam int unsigned WRITE_TX_LEN = 6;

    // Bus cycle captured on the address-strobe rising edge
    typedef struct packed {
        logic        rw;
        logic        uds;
        logic        lds;
        logic [2:0]  fc;
        logic [23:0] addr;
        logic [15:0] data;
    } bus_req_t;

    function automatic logic [7:0] make_hdr(input bus_req_t req);
        logic [7:0] h;
        h                      = '0;
        h[HDR_START_BIT]       = 1'b1;
        h[HDR_RW_BIT]          = req.rw;
        h[HDR_UDS_BIT]         = req.uds;
        h[HDR_LDS_BIT]         = req.lds;
        h[HDR_RSVD_BIT]        = 1'b0;
        h[HDR_FC_LSB +: 3]     = req.fc;
        return h;
    endfunction

    // Byte transmitted while in a given SEND_* state
    function automatic logic [7:0] pkt_byte(input bus_req_t req, input state_t s);
        logic [7:0] b;
        case (s)
            ST_SEND_HDR: b = make_hdr(req);
            ST_SEND_A2:  b = req.addr[23:16];
            ST_SEND_A1:  b = req.addr[15:8];
            ST_SEND_A0:  b = req.addr[7:0];
            ST_SEND_DH:  b = req.data[15:8];
            ST_SEND_DL:  b = req.data[7:0];
            default:     b = '0;
        endcase
        return b;
    endfunction

    // Position of a SEND_* state within the packet
    function automatic logic [2:0] tx_index(input state_t s);
        logic [2:0] i;
        case (s)
            ST_SEND_A2: i = 3'd1;
            ST_SEND_A1: i = 3'd2;
            ST_SEND_A0: i = 3'd3;
            ST_SEND_DH: i = 3'd4;
            ST_SEND_DL: i = 3'd5;
            default:    i = 3'd0;
        endcase
        return i;
    endfunction

    function automatic logic [2:0] pkt_last_index(input logic rw);
        return rw ? 3'(READ_TX_LEN - 1) : 3'(WRITE_TX_LEN - 1);
    endfunction

    function automatic state_t next_send(input state_t s);
        state_t n;
        case (s)
            ST_SEND_HDR: n = ST_SEND_A2;
            ST_SEND_A2:  n = ST_SEND_A1;
            ST_SEND_A1:  n = ST_SEND_A0;
            ST_SEND_A0:  n = ST_SEND_DH;
            ST_SEND_DH:  n = ST_SEND_DL;
            default:     n = ST_WAIT_STATUS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/m68k_uart_bus_bridge_uart_tx_seq.sv
// Single-byte UART transmit sequencer: holds the request until the transmitter takes it.
module uart_tx_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_c,
    input  logic [7:0] byte_c,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       done_c
);

    assign done_c = new_tx_data & ~tx_busy;

    // Load a new byte only when no request is stalled on a busy transmitter
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= '0;
            new_tx_data <= 1'b0;
        end else if (!(new_tx_data && tx_busy)) begin
            new_tx_data <= send_c;
            if (send_c) begin
                tx_data <= byte_c;
            end
        end
    end

endmodule

// File: rtl/m68k_uart_bus_bridge.sv
// Bus-slave bridge: serialises each 68000 bus cycle to the host over UART and
// holds the cycle open until the host answers with ACK (+read data) or NAK.
module m68k_uart_bus_bridge
    import m68k_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        as,
    input  logic        rw,
    input  logic        uds,
    input  logic        lds,
    input  logic [2:0]  fc,
    input  logic [23:0] addr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        d_out_en,
    output logic        dtack,
    output logic        berr,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic        idle
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_t           state_q, state_d;
    logic             as_q;
    bus_req_t         req_in, req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_c, send_c, tx_done_c, timeout_c, in_wait_c;
    logic [7:0]       byte_c;

    assign req_in    = {rw, uds, lds, fc, addr, d_in};
    assign in_wait_c = (state_q == ST_WAIT_STATUS) || (state_q == ST_RECV_DH) ||
                       (state_q == ST_RECV_DL);
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    uart_tx_seq u_tx_seq (
        .clk         (clk),
        .rst         (rst),
        .send_c      (send_c),
        .byte_c      (byte_c),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .done_c      (tx_done_c)
    );

    // Strobe history is kept through reset so a strobe held across reset is not a new cycle
    always_ff @(posedge clk) begin
        as_q <= as;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transmit request
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        send_c  = 1'b0;
        byte_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (as && !as_q) begin
                    start_c = 1'b1;
                    state_d = ST_SEND_HDR;
                    send_c  = 1'b1;
                    byte_c  = make_hdr(req_in);
                end
            end
            ST_SEND_HDR, ST_SEND_A2, ST_SEND_A1, ST_SEND_A0, ST_SEND_DH, ST_SEND_DL: begin
                if (tx_done_c) begin
                    if (!as) begin
                        state_d = ST_IDLE;
                    end else if (tx_index(state_q) == pkt_last_index(req_q.rw)) begin
                        state_d = ST_WAIT_STATUS;
                    end else begin
                        state_d = next_send(state_q);
                        send_c  = 1'b1;
                        byte_c  = pkt_byte(req_q, next_send(state_q));
                    end
                end
            end
            ST_WAIT_STATUS, ST_RECV_DH, ST_RECV_DL: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_DONE_ERR;
                end else if (new_rx_data) begin
                    case (state_q)
                        ST_WAIT_STATUS: begin
                            if (rx_data == ACK_BYTE) begin
                                state_d = req_q.rw ? ST_RECV_DH : ST_DONE_ACK;
                            end else if (rx_data == NAK_BYTE) begin
                                state_d = ST_DONE_ERR;
                            end
                        end
                        ST_RECV_DH: state_d = ST_RECV_DL;
                        default:    state_d = ST_DONE_ACK;
                    endcase
                end
            end
            ST_DONE_ACK, ST_DONE_ERR: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the bus cycle on the strobe edge
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (start_c) begin
            req_q <= req_in;
        end
    end

    // Host reply timeout counter, restarted on entry to WAIT_STATUS
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d == ST_WAIT_STATUS && state_q != ST_WAIT_STATUS) begin
            cnt_q <= '0;
        end else if (in_wait_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Read data capture from the host reply
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (state_q == ST_RECV_DH && state_d == ST_RECV_DL) begin
            d_out[15:8] <= rx_data;
        end else if (state_q == ST_RECV_DL && state_d == ST_DONE_ACK) begin
            d_out[7:0] <= rx_data;
        end
    end

    // Bus response outputs follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            dtack    <= 1'b0;
            berr     <= 1'b0;
            d_out_en <= 1'b0;
            idle     <= 1'b1;
        end else begin
            dtack    <= (state_d == ST_DONE_ACK);
            berr     <= (state_d == ST_DONE_ERR);
            d_out_en <= (state_d == ST_DONE_ACK) && req_q.rw;
            idle     <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_m68k_uart_bus_bridge.sv
// Self-checking bench for m68k_uart_bus_bridge with a packet/host-reply reference model.
module tb_m68k_uart_bus_bridge;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        as = 1'b0, rw = 1'b1, uds = 1'b0, lds = 1'b0;
    logic [2:0]  fc = '0;
    logic [23:0] addr = '0;
    logic [15:0] d_in = '0;
    logic [15:0] d_out;
    logic        d_out_en, dtack, berr, new_tx_data, idle;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        new_rx_data = 1'b0;

    int          n_pass = 0;
    int          n_checks = 0;
    byte unsigned host_q[$];
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    logic [15:0] exp_dout = '0;

    m68k_uart_bus_bridge #(
        .TIMEOUT_CYCLES (TO),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .as          (as),
        .rw          (rw),
        .uds         (uds),
        .lds         (lds),
        .fc          (fc),
        .addr        (addr),
        .d_in        (d_in),
        .d_out       (d_out),
        .d_out_en    (d_out_en),
        .dtack       (dtack),
        .berr        (berr),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full bus cycle: packet capture, host reply, strobe release.
    task automatic run_txn(input logic rw_i, input logic uds_i, input logic lds_i,
                           input logic [2:0] fc_i, input logic [23:0] a_i,
                           input logic [15:0] d_i, input int unsigned busy_pct,
                           input int hold_at);
        logic [7:0] hdr;
        bit         held, ack, err;
        int         cyc, k, first;
        hdr = {1'b1, rw_i, uds_i, lds_i, 1'b0, fc_i};
        exp_q.delete();
        exp_q.push_back(hdr);
        exp_q.push_back(a_i[23:16]);
        exp_q.push_back(a_i[15:8]);
        exp_q.push_back(a_i[7:0]);
        if (!rw_i) begin
            exp_q.push_back(d_i[15:8]);
            exp_q.push_back(d_i[7:0]);
        end
        got_q.delete();
        held = 1'b0;

        rw = rw_i; uds = uds_i; lds = lds_i; fc = fc_i; addr = a_i; d_in = d_i;
        tx_busy = 1'b0;
        as = 1'b1;
        @(negedge clk);
        chk("hdr_req_latency", 32'(new_tx_data), 32'd1);
        chk("hdr_byte", 32'(tx_data), 32'(hdr));
        // Bus lines may change once the cycle is captured
        rw = 1'($urandom); uds = 1'($urandom); lds = 1'($urandom);
        fc = 3'($urandom); addr = 24'($urandom); d_in = 16'($urandom);

        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 4000) begin
            if (hold_at >= 0 && got_q.size() == hold_at && !held) begin
                held = 1'b1;
                tx_busy = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("busy_hold_req", 32'(new_tx_data), 32'd1);
                    chk("busy_hold_byte", 32'(tx_data), 32'(exp_q[hold_at]));
                end
            end
            tx_busy = ($urandom_range(99) < busy_pct);
            if (new_tx_data && !tx_busy) got_q.push_back(tx_data);
            @(negedge clk);
            cyc++;
        end
        tx_busy = 1'b0;
        chk("pkt_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("pkt_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("req_low_after_pkt", 32'(new_tx_data), 32'd0);

        // Host reply model: first ACK/NAK decides; ACK on a read is followed by two data bytes
        ack = 1'b0; err = 1'b0; k = 0;
        while (k < host_q.size() && !ack && !err) begin
            if (host_q[k] == 8'h06) ack = 1'b1;
            else if (host_q[k] == 8'h15) err = 1'b1;
            k++;
        end
        if (ack && rw_i) exp_dout = {host_q[k], host_q[k+1]};

        if (!ack && !err) begin
            first = -1;
            for (int i = 1; i <= 300 && first < 0; i++) begin
                if (berr) first = i;
                else @(negedge clk);
            end
            chk("timeout_cycles", 32'(first), 32'(TO + 1));
        end else begin
            foreach (host_q[i]) begin
                repeat ($urandom_range(3)) @(negedge clk);
                chk("no_resp_early", {30'd0, dtack, berr}, 32'd0);
                rx_data = host_q[i];
                new_rx_data = 1'b1;
                @(negedge clk);
                new_rx_data = 1'b0;
                rx_data = 8'($urandom);
            end
        end
        chk("dtack", 32'(dtack), 32'(ack));
        chk("berr", 32'(berr), 32'(!ack));
        chk("d_out_en", 32'(d_out_en), 32'(ack && rw_i));
        chk("d_out", 32'(d_out), 32'(exp_dout));
        chk("busy_not_idle", 32'(idle), 32'd0);
        repeat ($urandom_range(4, 1)) @(negedge clk);
        chk("resp_hold", {30'd0, dtack, berr}, {30'd0, ack, !ack});
        as = 1'b0;
        @(negedge clk);
        chk("release_clear", {29'd0, dtack, berr, d_out_en}, 32'd0);
        chk("release_idle", 32'(idle), 32'd1);
        chk("release_dout_kept", 32'(d_out), 32'(exp_dout));
    endtask

    initial begin
        logic        r;
        byte unsigned b;
        bit          seen;
        logic [23:0] a_ab;

        repeat (3) @(negedge clk);
        chk("rst_outs", {28'd0, dtack, berr, d_out_en, new_tx_data}, 32'd0);
        chk("rst_data", {8'd0, d_out, tx_data}, 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(idle), 32'd1);

        // Read with data
        host_q = '{8'h06, 8'h12, 8'h34};
        run_txn(1'b1, 1'b1, 1'b1, 3'b110, 24'h00_0400, 16'h0000, 0, -1);
        // Write, lower strobe only
        host_q = '{8'h06};
        run_txn(1'b0, 1'b0, 1'b1, 3'b101, 24'hFF_0002, 16'hBEEF, 0, -1);
        // NAK on a read
        host_q = '{8'h15};
        run_txn(1'b1, 1'b1, 1'b1, 3'b001, 24'h12_3456, 16'h0000, 20, -1);
        // Stray byte ignored before ACK
        host_q = '{8'h41, 8'h06, 8'hAB, 8'hCD};
        run_txn(1'b1, 1'b1, 1'b0, 3'b010, 24'h00_0404, 16'h0000, 0, -1);
        // Transmitter busy for 10 cycles while A1 is offered
        host_q = '{8'h06, 8'h55, 8'hAA};
        run_txn(1'b1, 1'b1, 1'b1, 3'b110, 24'h00_0400, 16'h0000, 0, 2);
        // No reply: timeout
        host_q.delete();
        run_txn(1'b0, 1'b1, 1'b1, 3'b101, 24'h80_1234, 16'h1357, 30, -1);

        // Strobe dropped while A2 is stalled
        a_ab = 24'h5A_C3E1;
        as = 1'b1; rw = 1'b1; uds = 1'b1; lds = 1'b1; fc = 3'b010; addr = a_ab; tx_busy = 1'b0;
        @(negedge clk);
        chk("abort_hdr_req", 32'(new_tx_data), 32'd1);
        @(negedge clk);
        chk("abort_a2_offer", {23'd0, new_tx_data, tx_data}, {23'd0, 1'b1, a_ab[23:16]});
        tx_busy = 1'b1;
        as = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_a2_held", {23'd0, new_tx_data, tx_data}, {23'd0, 1'b1, a_ab[23:16]});
        end
        tx_busy = 1'b0;
        @(negedge clk);
        chk("abort_req_low", 32'(new_tx_data), 32'd0);
        chk("abort_no_resp", {30'd0, dtack, berr}, 32'd0);
        chk("abort_idle", 32'(idle), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (new_tx_data || dtack || berr || !idle) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        host_q = '{8'h06, 8'hC0, 8'hDE};
        run_txn(1'b1, 1'b0, 1'b1, 3'b001, 24'h00_00FE, 16'h0000, 10, -1);

        // Reply bytes while idle are dropped
        rx_data = 8'h06;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        @(negedge clk);
        chk("idle_rx_dropped", {29'd0, dtack, berr, idle}, 32'd1);

        // Reset in the middle of a bus cycle with the strobe still high
        as = 1'b1; rw = 1'b1; uds = 1'b1; lds = 1'b1; fc = 3'b110; addr = 24'h33_4455; tx_busy = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_dout = '0;
        chk("midrst_outs", {28'd0, dtack, berr, d_out_en, new_tx_data}, 32'd0);
        chk("midrst_data", {8'd0, d_out, tx_data}, 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (new_tx_data || !idle) seen = 1'b1;
        end
        chk("midrst_no_restart", 32'(seen), 32'd0);
        as = 1'b0;
        @(negedge clk);

        // Randomised bus cycles
        for (int t = 0; t < 20; t++) begin
            r = 1'($urandom);
            host_q.delete();
            repeat ($urandom_range(2)) begin
                b = 8'($urandom);
                while (b == 8'h06 || b == 8'h15) b = 8'($urandom);
                host_q.push_back(b);
            end
            if ($urandom_range(9) == 0) begin
                host_q.push_back(8'h15);
            end else begin
                host_q.push_back(8'h06);
                if (r) begin
                    host_q.push_back(8'($urandom));
                    host_q.push_back(8'($urandom));
                end
            end
            run_txn(r, 1'($urandom), 1'($urandom), 3'($urandom), 24'($urandom),
                    16'($urandom), $urandom_range(60), -1);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
